// File: rtl/dmem_bus_bridge.sv
// Data-memory bus bridge: turns one load/store from the memory-access stage into a
// single request/response bus transaction, with alignment, bus-error and timeout faults.
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [3:0]  strb,
    input  logic [31:0] wb_mask,
    input  logic [4:0]  wb_msb_bit,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        write_ready,
    output logic        read_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_strb,
    input  logic        bus_resp_valid,
    output logic        bus_resp_ready,
    input  logic [31:0] bus_resp_data,
    input  logic        bus_resp_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  off_q;
    logic [31:0] mask_q;
    logic [4:0]  msb_q;
    logic        is_write_q;

    logic        req;
    logic        mis_align;
    logic        timeout_hit;
    logic [3:0]  strb_sh;
    logic [31:0] wdata_sh;
    logic [31:0] shifted;
    logic [31:0] ext;

    always_comb begin
        req         = write_enable | read_enable;
        mis_align   = (strb == 4'b0011 && addr[0]) ||
                      (strb == 4'b1111 && addr[1:0] != 2'b00);
        // Shifting in a 4-bit context drops strobes that would cross the word.
        strb_sh     = strb << addr[1:0];
        wdata_sh    = wdata << {addr[1:0], 3'b000};
        shifted     = bus_resp_data >> {off_q, 3'b000};
        ext         = shifted & mask_q;
        if (msb_q != 5'd0 && shifted[msb_q])
            ext = ext | ~mask_q;
        // >= so the limit still fires in WAIT after the counter has passed it in REQ.
        timeout_hit = TO_EN && (cnt >= TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            off_q          <= '0;
            mask_q         <= '0;
            msb_q          <= '0;
            is_write_q     <= 1'b0;
            write_ready    <= 1'b0;
            read_valid     <= 1'b0;
            rdata          <= '0;
            misaligned     <= 1'b0;
            access_fault   <= 1'b0;
            bus_req_valid  <= 1'b0;
            bus_req_write  <= 1'b0;
            bus_req_addr   <= '0;
            bus_req_wdata  <= '0;
            bus_req_strb   <= '0;
            bus_resp_ready <= 1'b0;
        end else begin
            write_ready  <= 1'b0;
            read_valid   <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        off_q      <= addr[1:0];
                        mask_q     <= wb_mask;
                        msb_q      <= wb_msb_bit;
                        is_write_q <= write_enable;
                        if (ALIGN_CHECK && mis_align) begin
                            state       <= S_DONE;
                            misaligned  <= 1'b1;
                            write_ready <= write_enable;
                            read_valid  <= !write_enable;
                        end else begin
                            state         <= S_REQ;
                            cnt           <= '0;
                            bus_req_valid <= 1'b1;
                            bus_req_write <= write_enable;
                            bus_req_addr  <= {addr[31:2], 2'b00};
                            bus_req_wdata <= wdata_sh;
                            bus_req_strb  <= strb_sh;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (bus_req_ready) begin
                        state          <= S_WAIT;
                        bus_req_valid  <= 1'b0;
                        bus_resp_ready <= 1'b1;
                    end else if (timeout_hit) begin
                        state         <= S_DONE;
                        bus_req_valid <= 1'b0;
                        access_fault  <= 1'b1;
                        write_ready   <= is_write_q;
                        read_valid    <= !is_write_q;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (bus_resp_valid) begin
                        state          <= S_DONE;
                        bus_resp_ready <= 1'b0;
                        access_fault   <= bus_resp_err;
                        write_ready    <= is_write_q;
                        read_valid     <= !is_write_q;
                        rdata          <= (bus_resp_err || is_write_q) ? 32'd0 : ext;
                    end else if (timeout_hit) begin
                        state          <= S_DONE;
                        bus_resp_ready <= 1'b0;
                        access_fault   <= 1'b1;
                        write_ready    <= is_write_q;
                        read_valid     <= !is_write_q;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    rdata <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: one instance without timeout, one with
// TIMEOUT_CYCLES=4, both driven from the same upstream and bus inputs.
module tb_dmem_bus_bridge;
    logic        clk, rst_n;
    logic        we, re;
    logic [3:0]  strb;
    logic [31:0] mask;
    logic [4:0]  msb;
    logic [31:0] addr, wdata;
    logic        rq_rdy, rs_vld, rs_err;
    logic [31:0] rs_data;

    logic        wr, rv, mis, af, rqv, rqw, rsr;
    logic [31:0] rd, rqa, rqd;
    logic [3:0]  rqs;
    logic        wr_t, rv_t, mis_t, af_t, rqv_t, rqw_t, rsr_t;
    logic [31:0] rd_t, rqa_t, rqd_t;
    logic [3:0]  rqs_t;

    int n_chk = 0;
    int n_fail = 0;

    dmem_bus_bridge dut (
        .clk(clk), .rst_n(rst_n), .write_enable(we), .read_enable(re), .strb(strb),
        .wb_mask(mask), .wb_msb_bit(msb), .addr(addr), .wdata(wdata),
        .write_ready(wr), .read_valid(rv), .rdata(rd), .misaligned(mis), .access_fault(af),
        .bus_req_valid(rqv), .bus_req_ready(rq_rdy), .bus_req_write(rqw), .bus_req_addr(rqa),
        .bus_req_wdata(rqd), .bus_req_strb(rqs), .bus_resp_valid(rs_vld),
        .bus_resp_ready(rsr), .bus_resp_data(rs_data), .bus_resp_err(rs_err)
    );

    dmem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .write_enable(we), .read_enable(re), .strb(strb),
        .wb_mask(mask), .wb_msb_bit(msb), .addr(addr), .wdata(wdata),
        .write_ready(wr_t), .read_valid(rv_t), .rdata(rd_t), .misaligned(mis_t), .access_fault(af_t),
        .bus_req_valid(rqv_t), .bus_req_ready(rq_rdy), .bus_req_write(rqw_t), .bus_req_addr(rqa_t),
        .bus_req_wdata(rqd_t), .bus_req_strb(rqs_t), .bus_resp_valid(rs_vld),
        .bus_resp_ready(rsr_t), .bus_resp_data(rs_data), .bus_resp_err(rs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns just after entering cycle 1.
    task automatic start(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] m, input logic [4:0] b);
        we = w; re = r; addr = a; wdata = d; strb = s; mask = m; msb = b;
        tick();
        we = 1'b0; re = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; mask = 32'h0; msb = 5'd31;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({wr, rv, mis, af, rqv, rqw, rsr} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {wr, rv, mis, af, rqv, rqw, rsr}); end
        n_chk++; if ({rd, rqa, rqd, rqs} !== 100'b0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h expected all zero", rd, rqa, rqd, rqs); end
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        rq_rdy = 1'b1; rs_vld = 1'b1; rs_err = 1'b0; rs_data = 32'h80AA5511;
        start(1'b0, 1'b1, 32'h0000_1003, 32'h0, 4'b0001, 32'h0000_00FF, 5'd7);
        @(negedge clk);
        n_chk++; if (rqv !== 1'b1) begin n_fail++; $display("FAIL lb_req_valid: got %b expected 1", rqv); end
        n_chk++; if (rqa !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_req_addr: got %h expected 00001000", rqa); end
        n_chk++; if (rqw !== 1'b0) begin n_fail++; $display("FAIL lb_req_write: got %b expected 0", rqw); end
        tick(); @(negedge clk);
        n_chk++; if ({rsr, rv} !== 2'b10) begin n_fail++; $display("FAIL lb_wait: got rsr/rv %b expected 10", {rsr, rv}); end
        tick(); @(negedge clk);
        n_chk++; if (rv !== 1'b1) begin n_fail++; $display("FAIL lb_read_valid_c3: got %b expected 1", rv); end
        n_chk++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
        n_chk++; if ({af, mis} !== 2'b00) begin n_fail++; $display("FAIL lb_faults: got %b expected 00", {af, mis}); end
        tick(); @(negedge clk);
        n_chk++; if (rv !== 1'b0) begin n_fail++; $display("FAIL lb_pulse_end: got %b expected 0", rv); end
    endtask

    task automatic test_lhu();
        rs_data = 32'hBEEF1234;
        start(1'b0, 1'b1, 32'h0000_2002, 32'h0, 4'b0011, 32'h0000_FFFF, 5'd0);
        @(negedge clk);
        n_chk++; if (rqs !== 4'b1100) begin n_fail++; $display("FAIL lhu_strb: got %b expected 1100", rqs); end
        tick(); tick(); @(negedge clk);
        n_chk++; if ({rv, af} !== 2'b10) begin n_fail++; $display("FAIL lhu_valid: got rv/af %b expected 10", {rv, af}); end
        n_chk++; if (rd !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 0000beef", rd); end
        tick();
    endtask

    task automatic test_sb();
        start(1'b1, 1'b0, 32'h0000_3001, 32'h0000_00A5, 4'b0001, 32'h0, 5'd0);
        @(negedge clk);
        n_chk++; if (rqs !== 4'b0010) begin n_fail++; $display("FAIL sb_strb: got %b expected 0010", rqs); end
        n_chk++; if (rqd !== 32'h0000_A500) begin n_fail++; $display("FAIL sb_wdata: got %h expected 0000a500", rqd); end
        n_chk++; if ({rqw, rqa} !== {1'b1, 32'h0000_3000}) begin n_fail++; $display("FAIL sb_write_addr: got %b %h expected 1 00003000", rqw, rqa); end
        tick(); tick(); @(negedge clk);
        n_chk++; if ({wr, rv} !== 2'b10) begin n_fail++; $display("FAIL sb_write_ready: got wr/rv %b expected 10", {wr, rv}); end
        tick(); @(negedge clk);
        n_chk++; if (wr !== 1'b0) begin n_fail++; $display("FAIL sb_single_pulse: got %b expected 0", wr); end
    endtask

    task automatic test_misaligned();
        start(1'b1, 1'b0, 32'h0000_4002, 32'h1234_5678, 4'b1111, 32'h0, 5'd0);
        @(negedge clk);
        n_chk++; if ({wr, mis, rqv} !== 3'b110) begin n_fail++; $display("FAIL sw_misaligned: got wr/mis/rqv %b expected 110", {wr, mis, rqv}); end
        tick(); @(negedge clk);
        n_chk++; if ({wr, mis} !== 2'b00) begin n_fail++; $display("FAIL sw_mis_clear: got %b expected 00", {wr, mis}); end
        start(1'b0, 1'b1, 32'h0000_4001, 32'h0, 4'b0011, 32'h0000_FFFF, 5'd15);
        @(negedge clk);
        n_chk++; if ({rv, mis, rqv, rd} !== {3'b110, 32'h0}) begin n_fail++; $display("FAIL lh_misaligned: got rv/mis/rqv %b rdata %h expected 110 0", {rv, mis, rqv}, rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        rs_data = 32'h1122_3344;
        re = 1'b1; addr = 32'h0000_7000; strb = 4'b1111; mask = 32'hFFFF_FFFF; msb = 5'd0;
        for (int i = 1; i <= 8; i++) begin
            tick(); @(negedge clk);
            n_chk++; if (rv !== (i == 3 || i == 7)) begin n_fail++; $display("FAIL b2b_pulse_c%0d: got %b expected %b", i, rv, (i == 3 || i == 7)); end
            if (i == 8) re = 1'b0;
        end
        tick();
    endtask

    task automatic test_err_stall();
        rq_rdy = 1'b0; rs_vld = 1'b0;
        start(1'b0, 1'b1, 32'h0000_5000, 32'h0, 4'b1111, 32'hFFFF_FFFF, 5'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_chk++; if (rqv !== 1'b1) begin n_fail++; $display("FAIL stall_req_c%0d: got %b expected 1", i, rqv); end
            tick();
        end
        rq_rdy = 1'b1;
        tick();
        rq_rdy = 1'b0; rs_vld = 1'b1; rs_err = 1'b1; rs_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_chk++; if ({rsr, rv} !== 2'b10) begin n_fail++; $display("FAIL err_wait: got rsr/rv %b expected 10", {rsr, rv}); end
        tick();
        rs_vld = 1'b0; rs_err = 1'b0;
        @(negedge clk);
        n_chk++; if ({rv, af, rd} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL err_fault: got rv/af %b rdata %h expected 11 0", {rv, af}, rd); end
        n_chk++; if ({rv_t, af_t} !== 2'b11) begin n_fail++; $display("FAIL err_fault_to: got %b expected 11", {rv_t, af_t}); end
        tick();
    endtask

    task automatic test_timeout();
        rq_rdy = 1'b0; rs_vld = 1'b0;
        start(1'b0, 1'b1, 32'h0000_8000, 32'h0, 4'b1111, 32'hFFFF_FFFF, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_chk++; if ({rqv_t, rv_t} !== 2'b10) begin n_fail++; $display("FAIL to_req_c%0d: got rqv/rv %b expected 10", i, {rqv_t, rv_t}); end
            tick();
        end
        @(negedge clk);
        n_chk++; if ({rv_t, af_t, rqv_t, rd_t} !== {3'b110, 32'h0}) begin n_fail++; $display("FAIL to_fault: got rv/af/rqv %b rdata %h expected 110 0", {rv_t, af_t, rqv_t}, rd_t); end
        n_chk++; if ({rqv, rv} !== 2'b10) begin n_fail++; $display("FAIL to_disabled: got rqv/rv %b expected 10", {rqv, rv}); end
        tick(); @(negedge clk);
        n_chk++; if ({rv_t, af_t} !== 2'b00) begin n_fail++; $display("FAIL to_clear: got %b expected 00", {rv_t, af_t}); end
    endtask

    task automatic test_reset_in_wait();
        rq_rdy = 1'b1;
        tick();
        rq_rdy = 1'b0;
        @(negedge clk);
        n_chk++; if (rsr !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wait: got %b expected 1", rsr); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({rsr, rqv, rv, wr, af, mis} !== 6'b0) begin n_fail++; $display("FAIL rst_async_ctrl: got %b expected 000000", {rsr, rqv, rv, wr, af, mis}); end
        n_chk++; if ({rqa, rd, rqs} !== 68'b0) begin n_fail++; $display("FAIL rst_async_data: got %h %h %h expected zero", rqa, rd, rqs); end
        @(posedge clk); #1 rst_n = 1'b1;
        rs_vld = 1'b1; rs_err = 1'b1; rs_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++; if ({rv, af, rsr} !== 3'b000) begin n_fail++; $display("FAIL rst_stray_%0d: got rv/af/rsr %b expected 000", i, {rv, af, rsr}); end
            tick();
        end
        rq_rdy = 1'b1; rs_vld = 1'b1; rs_err = 1'b0; rs_data = 32'h8001_1234;
        start(1'b0, 1'b1, 32'h0000_6002, 32'h0, 4'b0011, 32'h0000_FFFF, 5'd15);
        tick(); tick(); @(negedge clk);
        n_chk++; if ({rv, af, rd} !== {2'b10, 32'hFFFF_8001}) begin n_fail++; $display("FAIL rst_next_load: got rv/af %b rdata %h expected 10 ffff8001", {rv, af}, rd); end
        n_chk++; if ({rv_t, rd_t} !== {1'b1, 32'hFFFF_8001}) begin n_fail++; $display("FAIL rst_next_load_to: got %b %h expected 1 ffff8001", rv_t, rd_t); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; strb = 4'b0; mask = 32'h0; msb = 5'd0;
        addr = 32'h0; wdata = 32'h0; rq_rdy = 1'b0; rs_vld = 1'b0; rs_err = 1'b0; rs_data = 32'h0;
        test_reset();
        test_lb();
        test_lhu();
        test_sb();
        test_misaligned();
        test_back_to_back();
        test_err_stall();
        test_timeout();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Data-memory bus bridge directly downstream of the memory-access decode stage.
- Consumes its write_enable/read_enable/strb/wb_mask/wb_msb_bit plus the effective address and store data, and runs a split request/response transaction on the data bus.
- Returns the write_ready/read_valid completion pulses that drive mem_stall upstream, along with the aligned, sign/zero-extended load result.
- Detects misaligned accesses, bus errors and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 0, cycles allowed in REQ+WAIT before an access fault; 0 disables the timeout.
- ALIGN_CHECK, 1, 1 raises a misaligned fault and issues no bus transaction; 0 forwards the access with strobes truncated to bits 3:0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- write_enable  in  1  store request from memory-access stage
- read_enable  in  1  load request from memory-access stage
- strb  in  4  byte strobe, LSB-aligned (0001/0011/1111)
- wb_mask  in  32  load result mask
- wb_msb_bit  in  5  sign bit index; 0 means zero-extend
- addr  in  32  effective byte address
- wdata  in  32  store data, LSB-aligned
- write_ready  out  1  one-cycle store completion pulse
- read_valid  out  1  one-cycle load completion pulse
- rdata  out  32  extended load result, valid with read_valid
- misaligned  out  1  misaligned fault, valid with the completion pulse
- access_fault  out  1  bus error or timeout, valid with the completion pulse
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus request accepted
- bus_req_write  out  1  1 = write
- bus_req_addr  out  32  word address {addr[31:2],2'b00}
- bus_req_wdata  out  32  wdata << (8*addr[1:0])
- bus_req_strb  out  4  strb << addr[1:0]
- bus_resp_valid  in  1  response valid
- bus_resp_ready  out  1  bridge accepts response
- bus_resp_data  in  32  read word
- bus_resp_err  in  1  bus error

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all outputs 0, including bus_req_*, rdata and the timeout counter. Any in-flight transaction is abandoned; a later stray bus response is ignored because bus_resp_ready=0 outside WAIT.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on write_enable|read_enable, latch addr, wdata, strb, wb_mask, wb_msb_bit and the direction. If both enables are high, write wins.
  - Misaligned (strb=0011 with addr[0]=1, or strb=1111 with addr[1:0]!=0) and ALIGN_CHECK=1: set misaligned and go to DONE, skipping the bus.
  - Otherwise: go to REQ.
- REQ: bus_req_valid=1 with the registered fields stable. On bus_req_ready, go to WAIT.
- WAIT: bus_resp_ready=1. On bus_resp_valid, capture data and err, then go to DONE.
- DONE, one cycle:
  - Pulse write_ready (store) or read_valid (load).
  - misaligned and access_fault are held valid during this cycle only.
  - Return to IDLE.
  - A request still asserted in the cycle after DONE is treated as a new access.
- Minimum latency: request seen in cycle 0, REQ in cycle 1 (ready=1), WAIT in cycle 2 (resp=1), completion pulse in cycle 3. Misaligned access: pulse in cycle 1.
- Timeout: when TIMEOUT_CYCLES>0, a counter clears on IDLE→REQ and increments each cycle in REQ/WAIT. On reaching TIMEOUT_CYCLES:
  - set access_fault;
  - drop bus_req_valid/bus_resp_ready;
  - go to DONE.
- Load extension: s = resp_data >> (8*addr_q[1:0]); m = s & wb_mask_q.
  - rdata = m | ({32{s[wb_msb_bit_q]}} & ~wb_mask_q) when wb_msb_bit_q != 0.
  - Otherwise rdata = m.
  - On fault, rdata = 0.
- Upstream inputs may change after the request cycle; only latched copies are used.
- The bridge has no pipelining: one outstanding transaction at most.

Test Plan:
- LB addr=0x1003, bus word 0x80AA5511, ready/resp immediate → bus_req_addr=0x1000; read_valid pulses in cycle 3 with rdata=0xFFFFFF80.
- LHU addr=0x2002, word 0xBEEF1234, wb_msb_bit=0 → rdata=0x0000BEEF, no fault.
- SB addr=0x3001, wdata=0x000000A5 → bus_req_strb=0010, bus_req_wdata=0x0000A500, bus_req_write=1; write_ready pulses once.
- SW addr=0x4002 → no bus_req_valid; write_ready+misaligned in cycle 1. LH addr=0x4001 gives the same with read_valid.
- bus_req_ready held low for 3 cycles, then bus_resp_err=1 → access_fault with read_valid, rdata=0. With TIMEOUT_CYCLES=4 and no ready → fault pulse after 4 REQ cycles.
- rst_n low while in WAIT → outputs 0 immediately. A later bus_resp_valid is ignored, and the next load completes normally.
